// File: rtl/noc_vc_packet_scheduler.sv
// Packet-granular round-robin arbiter sharing one NoC output link among NUM_REQ
// requesters; each packet is locked to one free virtual channel from header to tail.
`ifndef Noc_Data_Width
`define Noc_Data_Width 32
`endif

module noc_vc_packet_scheduler #(
  parameter int NUM_REQ = 4,
  parameter int NUM_VC  = 2,
  parameter int DATA_W  = `Noc_Data_Width
) (
  input  logic                      noc_clk,
  input  logic                      noc_rst,
  input  logic [NUM_REQ-1:0]        req_valid,
  output logic [NUM_REQ-1:0]        req_ready,
  input  logic [NUM_REQ*DATA_W-1:0] req_flit,
  input  logic [NUM_REQ-1:0]        req_is_header,
  input  logic [NUM_REQ-1:0]        req_is_tail,
  output logic [NUM_VC-1:0]         out_valid,
  input  logic [NUM_VC-1:0]         out_ready,
  input  logic [NUM_VC-1:0]         out_vc_ready,
  output logic [DATA_W-1:0]         out_flit,
  output logic                      out_is_header,
  output logic                      out_is_tail,
  output logic                      busy,
  output logic [2:0]                cur_req,
  output logic [1:0]                cur_vc,
  output logic [15:0]               pkt_count,
  output logic                      proto_err
);

  localparam int RW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int VW = (NUM_VC > 1) ? $clog2(NUM_VC) : 1;

  typedef enum logic {S_IDLE, S_XFER} state_t;

  state_t            state_q, state_d;
  logic [RW-1:0]     req_ptr_q, cur_req_q, grant_req;
  logic [VW-1:0]     vc_ptr_q, cur_vc_q, grant_vc;
  logic              found_req, found_vc;
  logic [NUM_REQ-1:0] req_elig;
  logic              fire, tail_fire, bad_req;
  logic [DATA_W-1:0] flit_arr [NUM_REQ];

  always_comb begin
    for (int i = 0; i < NUM_REQ; i++) begin
      flit_arr[i] = req_flit[i*DATA_W +: DATA_W];
    end
  end

  assign req_elig = req_valid & req_is_header;
  assign bad_req  = |(req_valid & ~req_is_header);

  // Requester search starts at req_ptr and wraps; the first eligible index wins.
  always_comb begin : p_req_arb
    logic [RW-1:0] idx;
    // NOTE: every variable written in a combinational block gets a default first,
    // otherwise paths that skip an assignment infer a latch.
    idx       = '0;
    found_req = 1'b0;
    grant_req = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      idx = RW'((int'(req_ptr_q) + k) % NUM_REQ);
      if (!found_req && req_elig[idx]) begin
        found_req = 1'b1;
        grant_req = idx;
      end
    end
  end

  always_comb begin : p_vc_arb
    logic [VW-1:0] idx;
    idx      = '0;
    found_vc = 1'b0;
    grant_vc = '0;
    for (int k = 0; k < NUM_VC; k++) begin
      idx = VW'((int'(vc_ptr_q) + k) % NUM_VC);
      if (!found_vc && out_vc_ready[idx]) begin
        found_vc = 1'b1;
        grant_vc = idx;
      end
    end
  end

  assign fire      = (state_q == S_XFER) && req_valid[cur_req_q] && out_ready[cur_vc_q];
  assign tail_fire = fire && req_is_tail[cur_req_q];

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (found_req && found_vc) state_d = S_XFER;
      S_XFER:  if (tail_fire) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Path outputs are gated by state only: a held-but-invalid flit still drives data.
  always_comb begin
    out_valid     = '0;
    req_ready     = '0;
    out_flit      = '0;
    out_is_header = 1'b0;
    out_is_tail   = 1'b0;
    if (state_q == S_XFER) begin
      out_valid[cur_vc_q]  = req_valid[cur_req_q];
      req_ready[cur_req_q] = out_ready[cur_vc_q];
      out_flit             = flit_arr[cur_req_q];
      out_is_header        = req_is_header[cur_req_q];
      out_is_tail          = req_is_tail[cur_req_q];
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples
  // pre-edge values regardless of statement order.
  always_ff @(posedge noc_clk) begin
    if (noc_rst) begin
      state_q   <= S_IDLE;
      req_ptr_q <= '0;
      vc_ptr_q  <= '0;
      cur_req_q <= '0;
      cur_vc_q  <= '0;
      pkt_count <= '0;
      proto_err <= 1'b0;
    end else begin
      state_q <= state_d;
      if (state_q == S_IDLE) begin
        if (bad_req) proto_err <= 1'b1;
        if (found_req && found_vc) begin
          cur_req_q <= grant_req;
          cur_vc_q  <= grant_vc;
        end
      end
      if (tail_fire) begin
        req_ptr_q <= RW'((int'(cur_req_q) + 1) % NUM_REQ);
        vc_ptr_q  <= VW'((int'(cur_vc_q) + 1) % NUM_VC);
        pkt_count <= pkt_count + 16'd1;
      end
    end
  end

  assign busy    = (state_q == S_XFER);
  assign cur_req = 3'(cur_req_q);
  assign cur_vc  = 2'(cur_vc_q);

endmodule

// File: tb/tb_noc_vc_packet_scheduler.sv
// Directed bench for noc_vc_packet_scheduler (NUM_REQ=4, NUM_VC=2, DATA_W=8).
module tb_noc_vc_packet_scheduler;

  localparam int NR = 4;
  localparam int NV = 2;
  localparam int DW = 8;

  logic              noc_clk = 1'b0;
  logic              noc_rst;
  logic [NR-1:0]     req_valid, req_ready, req_is_header, req_is_tail;
  logic [NR*DW-1:0]  req_flit;
  logic [NV-1:0]     out_valid, out_ready, out_vc_ready;
  logic [DW-1:0]     out_flit;
  logic              out_is_header, out_is_tail, busy, proto_err;
  logic [2:0]        cur_req;
  logic [1:0]        cur_vc;
  logic [15:0]       pkt_count;

  int n_checks = 0;
  int n_errors = 0;

  noc_vc_packet_scheduler #(.NUM_REQ(NR), .NUM_VC(NV), .DATA_W(DW)) dut (
    .noc_clk(noc_clk), .noc_rst(noc_rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_flit(req_flit),
    .req_is_header(req_is_header), .req_is_tail(req_is_tail),
    .out_valid(out_valid), .out_ready(out_ready), .out_vc_ready(out_vc_ready),
    .out_flit(out_flit), .out_is_header(out_is_header), .out_is_tail(out_is_tail),
    .busy(busy), .cur_req(cur_req), .cur_vc(cur_vc),
    .pkt_count(pkt_count), .proto_err(proto_err)
  );

  always #5 noc_clk = ~noc_clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Advance one clock; inputs change and outputs are sampled 1 ns after the edge.
  task automatic tick();
    @(posedge noc_clk);
    #1;
  endtask

  task automatic clr_in();
    req_valid     = '0;
    req_is_header = '0;
    req_is_tail   = '0;
    req_flit      = '0;
  endtask

  task automatic drive(input int r, input logic [7:0] f, input logic hdr, input logic tl);
    req_valid[r]     = 1'b1;
    req_flit[r*DW +: DW] = f;
    req_is_header[r] = hdr;
    req_is_tail[r]   = tl;
  endtask

  initial begin
    logic [2:0] exp_req [4];
    logic [1:0] exp_vc  [4];
    exp_req = '{3'd0, 3'd3, 3'd0, 3'd3};
    exp_vc  = '{2'd0, 2'd1, 2'd0, 2'd1};

    clr_in();
    out_ready    = 2'b11;
    out_vc_ready = 2'b11;
    noc_rst      = 1'b1;
    tick(); tick();
    noc_rst = 1'b0;
    #1;
    check("rst_busy",      32'(busy), 32'd0);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_req_ready", 32'(req_ready), 32'd0);
    check("rst_out_flit",  32'(out_flit), 32'd0);
    check("rst_pkt_count", 32'(pkt_count), 32'd0);
    check("rst_proto_err", 32'(proto_err), 32'd0);
    check("rst_cur",       32'({cur_req, cur_vc}), 32'd0);

    // Single 3-flit packet from requester 2.
    drive(2, 8'h0A, 1'b1, 1'b0);
    #1;
    check("sp_idle_busy",  32'(busy), 32'd0);
    check("sp_idle_ready", 32'(req_ready), 32'd0);
    check("sp_idle_valid", 32'(out_valid), 32'd0);
    tick();
    check("sp_busy",    32'(busy), 32'd1);
    check("sp_cur_req", 32'(cur_req), 32'd2);
    check("sp_cur_vc",  32'(cur_vc), 32'd0);
    check("sp_h_valid", 32'(out_valid), 32'b01);
    check("sp_h_ready", 32'(req_ready), 32'b0100);
    check("sp_h_flit",  32'(out_flit), 32'h0A);
    check("sp_h_hdr",   32'(out_is_header), 32'd1);
    tick();
    drive(2, 8'h0B, 1'b0, 1'b0);
    #1;
    check("sp_b_valid", 32'(out_valid), 32'b01);
    check("sp_b_flit",  32'(out_flit), 32'h0B);
    tick();
    drive(2, 8'h0C, 1'b0, 1'b1);
    #1;
    check("sp_t_valid", 32'(out_valid), 32'b01);
    check("sp_t_flit",  32'(out_flit), 32'h0C);
    check("sp_t_tail",  32'(out_is_tail), 32'd1);
    tick();
    clr_in();
    #1;
    check("sp_done_busy", 32'(busy), 32'd0);
    check("sp_pkt_count", 32'(pkt_count), 32'd1);

    // Pointers now req_ptr=3, vc_ptr=1: requester 3 must beat 2, on VC1.
    drive(2, 8'h21, 1'b1, 1'b1);
    drive(3, 8'h31, 1'b1, 1'b1);
    tick();
    check("ptr_cur_req", 32'(cur_req), 32'd3);
    check("ptr_cur_vc",  32'(cur_vc), 32'd1);
    check("ptr_valid",   32'(out_valid), 32'b10);
    check("ptr_flit",    32'(out_flit), 32'h31);
    tick();
    clr_in();
    #1;
    check("ptr_pkt_count", 32'(pkt_count), 32'd2);

    // Round-robin between requesters 0 and 3 with single-flit packets.
    drive(0, 8'h01, 1'b1, 1'b1);
    drive(3, 8'h03, 1'b1, 1'b1);
    for (int p = 0; p < 4; p++) begin
      #1;
      check($sformatf("rr%0d_bubble", p), 32'({busy, out_valid}), 32'd0);
      tick();
      check($sformatf("rr%0d_req", p), 32'(cur_req), 32'(exp_req[p]));
      check($sformatf("rr%0d_vc", p), 32'(cur_vc), 32'(exp_vc[p]));
      check($sformatf("rr%0d_valid", p), 32'(out_valid), 32'(2'b01 << exp_vc[p]));
      tick();
    end
    clr_in();
    #1;
    check("rr_pkt_count", 32'(pkt_count), 32'd6);

    // VC backpressure: no VC free, requester 1 waits in IDLE.
    out_vc_ready = 2'b00;
    drive(1, 8'h51, 1'b1, 1'b1);
    for (int c = 0; c < 3; c++) begin
      #1;
      check($sformatf("vcbp%0d_busy", c), 32'(busy), 32'd0);
      check($sformatf("vcbp%0d_ready", c), 32'(req_ready), 32'd0);
      tick();
    end
    out_vc_ready = 2'b10;
    tick();
    check("vcbp_cur_vc", 32'(cur_vc), 32'd1);
    check("vcbp_valid",  32'(out_valid), 32'b10);
    check("vcbp_ready",  32'(req_ready), 32'b0010);
    tick();
    clr_in();
    out_vc_ready = 2'b11;
    #1;
    check("vcbp_pkt_count", 32'(pkt_count), 32'd7);

    // Mid-packet stall on requester 2 (req_ptr=2, vc_ptr=0).
    drive(2, 8'h61, 1'b1, 1'b0);
    tick();
    check("st_cur_req", 32'(cur_req), 32'd2);
    tick();
    drive(2, 8'h62, 1'b0, 1'b0);
    out_ready    = 2'b00;
    out_vc_ready = 2'b00;
    for (int c = 0; c < 5; c++) begin
      #1;
      check($sformatf("st%0d_flit", c), 32'(out_flit), 32'h62);
      check($sformatf("st%0d_ready", c), 32'(req_ready), 32'd0);
      check($sformatf("st%0d_busy_valid", c), 32'({busy, out_valid}), 32'b101);
      tick();
    end
    out_ready = 2'b11;
    #1;
    check("st_rel_ready", 32'(req_ready), 32'b0100);
    check("st_rel_flit",  32'(out_flit), 32'h62);
    tick();
    drive(2, 8'h63, 1'b0, 1'b1);
    out_vc_ready = 2'b11;
    #1;
    check("st_tail_flit", 32'(out_flit), 32'h63);
    check("st_mid_count", 32'(pkt_count), 32'd7);
    tick();
    clr_in();
    #1;
    check("st_pkt_count", 32'(pkt_count), 32'd8);
    check("st_done_busy", 32'(busy), 32'd0);

    // Protocol error: requester 0 non-header, requester 1 header (req_ptr=3, vc_ptr=1).
    drive(0, 8'h7F, 1'b0, 1'b0);
    drive(1, 8'h11, 1'b1, 1'b1);
    #1;
    check("pe_before", 32'(proto_err), 32'd0);
    tick();
    check("pe_set",     32'(proto_err), 32'd1);
    check("pe_cur_req", 32'(cur_req), 32'd1);
    check("pe_cur_vc",  32'(cur_vc), 32'd1);
    check("pe_ready",   32'(req_ready), 32'b0010);
    tick();
    clr_in();
    tick();
    check("pe_sticky",    32'(proto_err), 32'd1);
    check("pe_pkt_count", 32'(pkt_count), 32'd9);

    // Reset mid-packet on requester 3 (req_ptr=2, vc_ptr=0).
    drive(3, 8'h71, 1'b1, 1'b0);
    tick();
    check("rm_cur_req", 32'(cur_req), 32'd3);
    tick();
    drive(3, 8'h72, 1'b0, 1'b0);
    noc_rst = 1'b1;
    tick();
    check("rm_valid_ready", 32'({out_valid, req_ready}), 32'd0);
    check("rm_flit_marks",  32'({out_flit, out_is_header, out_is_tail}), 32'd0);
    check("rm_busy",        32'(busy), 32'd0);
    check("rm_pkt_count",   32'(pkt_count), 32'd0);
    check("rm_proto_err",   32'(proto_err), 32'd0);
    check("rm_cur",         32'({cur_req, cur_vc}), 32'd0);
    clr_in();
    tick();
    noc_rst = 1'b0;
    drive(1, 8'h81, 1'b1, 1'b1);
    drive(3, 8'h83, 1'b1, 1'b1);
    tick();
    check("rm_rearb_req",  32'(cur_req), 32'd1);
    check("rm_rearb_vc",   32'(cur_vc), 32'd0);
    check("rm_rearb_flit", 32'(out_flit), 32'h81);
    tick();
    clr_in();
    #1;
    check("rm_pkt_after", 32'(pkt_count), 32'd1);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
